chip_test_sequencer: RTL and testbench
======================================

// Module: chip_test_sequencer
// PURPOSE
//   Front-panel controller directly upstream of the per-chip testers (chip_7400 etc.).
//   Latches a chip selection on Start and pulses that tester's Run for one cycle.
//   Waits for the tester's Done, samples its RSLT, and acknowledges with DISP_RSLT.
//   Drives pass/fail/timeout LEDs and blocks re-launch for a fixed display hold time.
// PARAMETERS
//   NUM_CHIPS    8         number of attached testers (one Run/Done/RSLT lane each)
//   SEL_W        3         width of Chip_Sel
//   TIMEOUT_CYC  1024      max cycles in WAIT_DONE before the test is declared timed out
//   HOLD_CYC     50000000  cycles spent in SHOW before a new Start is accepted
// PORTS
//   Clk        in   1          system clock; all state on posedge
//   Reset      in   1          asynchronous, active-low reset
//   Start      in   1          synchronous level from debounced button; rising edge launches
//   Chip_Sel   in   SEL_W      index of tester to run; sampled on the accepted Start edge
//   Done_bus   in   NUM_CHIPS  Done from each tester
//   RSLT_bus   in   NUM_CHIPS  RSLT from each tester (1 = pass)
//   Run_bus    out  NUM_CHIPS  one-hot, one-cycle Run pulse to the selected tester
//   DISP_RSLT  out  1          one-cycle ack to the selected tester; returns it to Halted
//   Busy       out  1          high in every state except IDLE
//   Pass_LED   out  1          last test passed
//   Fail_LED   out  1          last test failed, timed out, or had a bad selection
//   TO_LED     out  1          last test timed out
// BEHAVIOUR
//   Reset (async, Reset=0): state=IDLE; sel=0; all outputs 0; counters 0; start_q=0.
//   Start edge = Start & ~start_q (start_q registered every cycle, including outside IDLE).
//   Run_bus, DISP_RSLT, Busy and all LEDs are registered outputs.
//   FSM:
//     IDLE: on a Start edge, latch sel=Chip_Sel and clear all LEDs.
//       If sel >= NUM_CHIPS: Fail_LED=1, go to SHOW. Run is not issued.
//       Otherwise Run_bus[sel]=1 for the next cycle only, go to LAUNCH.
//     LAUNCH (1 cycle; Run pulse visible): clear cnt, go to WAIT_DONE.
//     WAIT_DONE: cnt++ each cycle.
//       If Done_bus[sel]: go to CAPTURE.
//       Else if cnt==TIMEOUT_CYC-1: TO_LED=1, Fail_LED=1, DISP_RSLT=1 for one cycle, go to SHOW.
//       If Done and the timeout fire in the same cycle, Done wins.
//     CAPTURE (1 cycle): the tester is in Done_s and RSLT_bus[sel] is final.
//       Pass_LED=RSLT_bus[sel]; Fail_LED=~RSLT_bus[sel].
//       DISP_RSLT=1 for exactly this one following cycle; go to SHOW.
//     SHOW: cnt counts 0..HOLD_CYC-1 and then returns to IDLE. Start edges are ignored.
//   LEDs hold their value in IDLE until the next accepted Start edge.
//   Done_bus/RSLT_bus on unselected lanes are ignored.
//   Start held high across IDLE re-entry does not relaunch; a fresh rising edge is required.
//   Launch latency: Start edge at cycle N -> Run_bus high in cycle N+1 only.
//   Result latency: Done seen at cycle M -> LEDs and DISP_RSLT valid from M+2.
//   Counter width is $clog2(max(TIMEOUT_CYC,HOLD_CYC)+1). No wrap is possible.
//   Reset mid-test: Run_bus and DISP_RSLT drop at once.
//     The tester is reset by the same Reset net and needs no ack.
// TESTING
//   1 Sel=0, model NAND-good tester (Done 5 cyc after Run, RSLT=1)
//     -> one Run_bus[0] pulse; DISP_RSLT one cycle; Pass_LED=1; Busy for the hold period.
//   2 Sel=2, tester with RSLT=0 -> Fail_LED=1, Pass_LED=0; Run_bus[2] only, never other lanes.
//   3 Sel=1, Done never asserted, TIMEOUT_CYC=16
//     -> TO_LED=1 and Fail_LED=1 exactly 16 cycles after LAUNCH; DISP_RSLT pulsed once.
//   4 Sel=9 with NUM_CHIPS=8 -> no Run pulse; Fail_LED=1; SHOW entered; TO_LED=0.
//   5 Start held high through SHOW into IDLE, then toggled
//     -> exactly one launch per rising edge; Start edges during SHOW are ignored.
//   6 Reset=0 asserted in WAIT_DONE mid-test
//     -> all outputs 0 asynchronously; after release, IDLE and a clean relaunch works.

Source files
------------

// File: rtl/chip_test_sequencer.sv
// rtl/chip_test_sequencer.sv - front-panel launcher for per-chip testers
// Pulses the selected tester's Run, waits for Done or timeout, shows the verdict on LEDs for a hold time.
module chip_test_sequencer #(
    parameter int NUM_CHIPS   = 8,
    parameter int SEL_W       = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int HOLD_CYC    = 50000000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [SEL_W-1:0]     Chip_Sel,
    input  logic [NUM_CHIPS-1:0] Done_bus,
    input  logic [NUM_CHIPS-1:0] RSLT_bus,
    output logic [NUM_CHIPS-1:0] Run_bus,
    output logic                 DISP_RSLT,
    output logic                 Busy,
    output logic                 Pass_LED,
    output logic                 Fail_LED,
    output logic                 TO_LED
);

    localparam int CNT_MAX = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_CAPTURE,
        S_SHOW
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CHIPS-1:0] sel_oh_q, sel_oh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 start_q;
    logic [NUM_CHIPS-1:0] run_q, run_d;
    logic                 disp_q, disp_d;
    logic                 busy_q, busy_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 to_q, to_d;

    logic [NUM_CHIPS-1:0] sel_oh_in;
    logic                 sel_valid;
    logic                 start_edge;
    logic                 lane_done;
    logic                 lane_rslt;

    // The selection is kept one-hot; an out-of-range index decodes to all zeros.
    always_comb begin
        sel_oh_in = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            sel_oh_in[i] = (Chip_Sel == SEL_W'(i));
        end
    end

    assign sel_valid  = |sel_oh_in;
    assign start_edge = Start & ~start_q;
    assign lane_done  = |(Done_bus & sel_oh_q);
    assign lane_rslt  = |(RSLT_bus & sel_oh_q);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            sel_oh_q <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            run_q    <= '0;
            disp_q   <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_oh_q <= sel_oh_d;
            cnt_q    <= cnt_d;
            start_q  <= Start;
            run_q    <= run_d;
            disp_q   <= disp_d;
            busy_q   <= busy_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_oh_d = sel_oh_q;
        cnt_d    = cnt_q;
        run_d    = '0;
        disp_d   = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    sel_oh_d = sel_oh_in;
                    pass_d   = 1'b0;
                    to_d     = 1'b0;
                    cnt_d    = '0;
                    if (sel_valid) begin
                        fail_d  = 1'b0;
                        run_d   = sel_oh_in;
                        state_d = S_LAUNCH;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = S_SHOW;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Done takes priority over a timeout expiring in the same cycle.
                if (lane_done) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    fail_d  = 1'b1;
                    disp_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHOW;
                end
            end
            S_CAPTURE: begin
                pass_d  = lane_rslt;
                fail_d  = ~lane_rslt;
                disp_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign Run_bus   = run_q;
    assign DISP_RSLT = disp_q;
    assign Busy      = busy_q;
    assign Pass_LED  = pass_q;
    assign Fail_LED  = fail_q;
    assign TO_LED    = to_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// tb/tb_chip_test_sequencer.sv - scoreboard bench for chip_test_sequencer
module tb_chip_test_sequencer;

    localparam int NC   = 8;
    localparam int SW   = 4;
    localparam int TO   = 16;
    localparam int HOLD = 20;

    localparam int EV_RUN  = 0;
    localparam int EV_DISP = 1;
    localparam int EV_IDLE = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [SW-1:0] Chip_Sel = '0;
    logic [NC-1:0] Done_bus = '0;
    logic [NC-1:0] RSLT_bus = '0;
    logic [NC-1:0] Run_bus;
    logic          DISP_RSLT, Busy, Pass_LED, Fail_LED, TO_LED;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          kind;
        logic [NC-1:0] val;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];

    chip_test_sequencer #(
        .NUM_CHIPS(NC), .SEL_W(SW), .TIMEOUT_CYC(TO), .HOLD_CYC(HOLD)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Chip_Sel(Chip_Sel),
        .Done_bus(Done_bus), .RSLT_bus(RSLT_bus), .Run_bus(Run_bus),
        .DISP_RSLT(DISP_RSLT), .Busy(Busy), .Pass_LED(Pass_LED),
        .Fail_LED(Fail_LED), .TO_LED(TO_LED)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [NC-1:0] leds(input logic to, input logic f, input logic p);
        return NC'({to, f, p});
    endfunction

    task automatic push(input int kind, input logic [NC-1:0] val, input int c);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic pop_check(input int kind, input logic [NC-1:0] val, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected output value %h at cycle %0d, nothing expected", nm, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: got kind %0d value %h cycle %0d, expected kind %0d value %h cycle %0d",
                         nm, kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every visible output event must match the head of the expected queue.
    logic prev_busy = 1'b0;
    always @(negedge Clk) begin
        if (Run_bus !== '0) pop_check(EV_RUN, Run_bus, "run_pulse");
        if (DISP_RSLT) pop_check(EV_DISP, leds(TO_LED, Fail_LED, Pass_LED), "disp_result");
        if (prev_busy && !Busy) pop_check(EV_IDLE, leds(TO_LED, Fail_LED, Pass_LED), "idle_return");
        prev_busy <= Busy;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_lanes(input int sel, input bit valid, input bit done, input bit rslt);
        logic [NC-1:0] m, nd, nr;
        bit            r;
        m  = valid ? (NC'(1) << sel) : '0;
        nd = NC'($urandom);
        nr = NC'($urandom);
        r  = done ? rslt : 1'($urandom_range(0, 1));
        Done_bus = (nd & ~m) | (done ? m : '0);
        RSLT_bus = (nr & ~m) | (r ? m : '0);
    endtask

    // hold_mode: 0 Start low at IDLE re-entry, 1 Start held high, 2 random
    task automatic do_test(input int sel, input int d, input bit rslt, input int hold_mode);
        int            s, r, disp_c, idle_c;
        bit            valid, done_en, hold_v;
        logic [NC-1:0] lv;
        valid   = (sel < NC);
        done_en = valid && (d <= TO);
        hold_v  = (hold_mode == 2) ? 1'($urandom_range(0, 1)) : (hold_mode == 1);
        tick();
        Start = 1'b0;
        drive_lanes(sel, 1'b0, 1'b0, rslt);
        tick();
        s = cyc;
        Start = 1'b1;
        Chip_Sel = SW'(sel);
        r = s + 1;
        if (!valid) begin
            idle_c = s + 1 + HOLD;
            disp_c = idle_c;
            push(EV_IDLE, leds(1'b0, 1'b1, 1'b0), idle_c);
        end else begin
            push(EV_RUN, NC'(1) << sel, r);
            if (done_en) begin
                disp_c = r + d + 2;
                lv     = leds(1'b0, ~rslt, rslt);
            end else begin
                disp_c = r + TO + 1;
                lv     = leds(1'b1, 1'b1, 1'b0);
            end
            idle_c = disp_c + HOLD;
            push(EV_DISP, lv, disp_c);
            push(EV_IDLE, lv, idle_c);
        end
        drive_lanes(sel, valid, 1'b0, rslt);
        while (cyc < idle_c + 1) begin
            tick();
            Chip_Sel = SW'($urandom_range(0, 15));
            if (cyc <= idle_c - 2) Start = 1'($urandom_range(0, 1));
            else Start = hold_v;
            drive_lanes(sel, valid, done_en && cyc >= r + d && cyc < disp_c, rslt);
        end
    endtask

    task automatic do_reset_test(input int sel, input int k);
        int r;
        tick();
        Start = 1'b0;
        tick();
        Start = 1'b1;
        Chip_Sel = SW'(sel);
        r = cyc + 1;
        push(EV_RUN, NC'(1) << sel, r);
        drive_lanes(sel, 1'b1, 1'b0, 1'b0);
        repeat (k + 1) begin
            tick();
            Start = 1'b0;
            drive_lanes(sel, 1'b1, 1'b0, 1'b0);
        end
        #2;
        push(EV_IDLE, leds(1'b0, 1'b0, 1'b0), cyc);
        Reset = 1'b0;
        #1;
        chk("rst_mid_run", 32'(Run_bus), 32'd0);
        chk("rst_mid_disp", 32'(DISP_RSLT), 32'd0);
        chk("rst_mid_busy", 32'(Busy), 32'd0);
        chk("rst_mid_leds", 32'({TO_LED, Fail_LED, Pass_LED}), 32'd0);
        tick();
        tick();
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_run", 32'(Run_bus), 32'd0);
        chk("reset_disp", 32'(DISP_RSLT), 32'd0);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_leds", 32'({TO_LED, Fail_LED, Pass_LED}), 32'd0);
        Reset = 1'b1;
        tick();

        do_test(0, 5, 1'b1, 0);
        do_test(2, 7, 1'b0, 1);
        do_test(1, 100, 1'b1, 1);
        do_test(9, 3, 1'b1, 0);
        do_test(3, TO, 1'b1, 2);
        do_test(4, TO + 1, 1'b1, 2);
        do_test(7, 1, 1'b0, 1);
        do_test(15, 1, 1'b1, 1);
        do_reset_test(5, 6);
        do_test(5, 4, 1'b1, 0);
        for (int i = 0; i < 24; i++) begin
            do_test($urandom_range(0, 9), $urandom_range(1, TO + 3), 1'($urandom_range(0, 1)), 2);
        end

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
